// File: rtl/airi5c_hasti_initiator.sv
// AHB-Lite (HASTI) bus master that turns a valid/ready command into single NONSEQ transfers.
// One transfer is in flight at a time; wait states, ERROR responses and a data-phase timeout are handled.
module airi5c_hasti_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic        hmastlock,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [31:0]   wdata_reg, wdata_next;
  logic [31:0]   haddr_next, hwdata_next, rsp_rdata_next;
  logic [2:0]    hsize_next;
  logic [1:0]    htrans_next;
  logic          hwrite_next, rsp_valid_next, rsp_error_next, rsp_timeout_next;
  logic          illegal;

  assign hburst    = HBURST_SINGLE;
  assign hmastlock = 1'b0;
  assign hprot     = HPROT_VAL;
  assign cnt_inc   = cnt_reg + CW'(1);
  assign illegal   = (cmd_size > 3'd2) || (cmd_size == 3'd1 && cmd_addr[0]) ||
                     (cmd_size == 3'd2 && cmd_addr[1:0] != 2'b00);

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    wdata_next       = wdata_reg;
    haddr_next       = haddr;
    hwrite_next      = hwrite;
    hsize_next       = hsize;
    htrans_next      = htrans;
    hwdata_next      = hwdata;
    rsp_valid_next   = 1'b0;
    rsp_rdata_next   = 32'h0;
    rsp_error_next   = 1'b0;
    rsp_timeout_next = 1'b0;
    cmd_ready        = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (illegal) begin
            rsp_valid_next = 1'b1;
            rsp_error_next = 1'b1;
          end else begin
            haddr_next  = cmd_addr;
            hwrite_next = cmd_write;
            hsize_next  = cmd_size;
            wdata_next  = cmd_wdata;
            htrans_next = HTRANS_NONSEQ;
            state_next  = ADDR;
          end
        end
      end
      ADDR: begin
        if (hready) begin
          htrans_next = HTRANS_IDLE;
          hwdata_next = hwrite ? wdata_reg : 32'h0;
          cnt_next    = '0;
          state_next  = DATA;
        end
      end
      DATA: begin
        if (hready) begin
          rsp_valid_next = 1'b1;
          rsp_error_next = hresp;
          rsp_rdata_next = (hresp || hwrite) ? 32'h0 : hrdata;
          hwdata_next    = 32'h0;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_inc;
          // Abort on the stalled cycle that brings the count to the limit.
          if (TIMEOUT_CYCLES != 0 && cnt_inc == CW'(TIMEOUT_CYCLES)) begin
            rsp_valid_next   = 1'b1;
            rsp_timeout_next = 1'b1;
            hwdata_next      = 32'h0;
            state_next       = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      wdata_reg   <= 32'h0;
      haddr       <= 32'h0;
      hwrite      <= 1'b0;
      hsize       <= 3'd0;
      htrans      <= HTRANS_IDLE;
      hwdata      <= 32'h0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wdata_reg   <= wdata_next;
      haddr       <= haddr_next;
      hwrite      <= hwrite_next;
      hsize       <= hsize_next;
      htrans      <= htrans_next;
      hwdata      <= hwdata_next;
      rsp_valid   <= rsp_valid_next;
      rsp_rdata   <= rsp_rdata_next;
      rsp_error   <= rsp_error_next;
      rsp_timeout <= rsp_timeout_next;
    end
  end

endmodule

// File: tb/tb_airi5c_hasti_initiator.sv
// Bench for airi5c_hasti_initiator: a per-cycle schedule of stimulus and expected outputs is
// built from the transfer rules first, then replayed while every cycle is compared.
module tb_airi5c_hasti_initiator;
  localparam int TO   = 4;
  localparam int MAXC = 6000;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hmastlock, hready, hresp;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  always #5 clk = ~clk;

  airi5c_hasti_initiator #(.TIMEOUT_CYCLES(TO), .HPROT_VAL(4'b0011)) dut (
    .clk(clk), .nreset(nreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  int   errors = 0;
  int   checks = 0;
  int   cur;
  int   cyc_idx = 0;
  logic run_en = 1'b0;

  // stimulus schedule
  logic        st_valid [MAXC];
  logic        st_write [MAXC];
  logic [31:0] st_addr  [MAXC];
  logic [2:0]  st_size  [MAXC];
  logic [31:0] st_wdata [MAXC];
  logic        st_hready[MAXC];
  logic        st_hresp [MAXC];
  logic [31:0] st_hrdata[MAXC];
  // expected outputs
  logic        ex_ready [MAXC];
  logic [1:0]  ex_htrans[MAXC];
  logic [31:0] ex_haddr [MAXC];
  logic        ex_hwrite[MAXC];
  logic [2:0]  ex_hsize [MAXC];
  logic [31:0] ex_hwdata[MAXC];
  logic        ex_rv    [MAXC];
  logic [31:0] ex_rdata [MAXC];
  logic        ex_rerr  [MAXC];
  logic        ex_rto   [MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic junk(input int c);
    st_valid[c] = 1'($urandom_range(0, 1));
    st_write[c] = 1'($urandom_range(0, 1));
    st_addr[c]  = $urandom;
    st_size[c]  = 3'($urandom_range(0, 7));
    st_wdata[c] = $urandom;
  endtask

  // Schedules one command accepted at cycle cur; slave stalls ast address cycles and dst data cycles.
  task automatic add_txn(input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input int ast, input int dst,
                         input logic err, input int gap, output int n);
    int d, stalls, l, r;
    logic legal, to, hr, hs;
    n = cur;
    st_valid[n] = 1'b1; st_write[n] = w; st_addr[n] = a; st_size[n] = sz; st_wdata[n] = wd;
    legal = !((sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00));
    if (!legal) begin
      ex_rv[n+1] = 1'b1; ex_rerr[n+1] = 1'b1;
      cur = n + 1 + gap;
      return;
    end
    for (int i = 0; i <= ast; i++) begin
      ex_htrans[n+1+i] = T_NONSEQ; ex_haddr[n+1+i] = a; ex_hwrite[n+1+i] = w;
      ex_hsize[n+1+i] = sz; ex_ready[n+1+i] = 1'b0;
      st_hready[n+1+i] = (i == ast); st_hresp[n+1+i] = 1'b0;
      junk(n + 1 + i);
    end
    d = n + 2 + ast; stalls = 0; to = 1'b0; l = d;
    for (int k = 0; k < 64; k++) begin
      if (k < dst)              begin hr = 1'b0; hs = 1'b0; end
      else if (err && k == dst) begin hr = 1'b0; hs = 1'b1; end
      else                      begin hr = 1'b1; hs = err;  end
      st_hready[d+k] = hr; st_hresp[d+k] = hs;
      ex_ready[d+k] = 1'b0; ex_hwdata[d+k] = w ? wd : 32'h0;
      junk(d + k);
      l = d + k;
      if (hr) break;
      stalls++;
      if (stalls == TO) begin to = 1'b1; break; end
    end
    r = l + 1;
    ex_rv[r] = 1'b1; ex_rto[r] = to; ex_rerr[r] = !to && err;
    ex_rdata[r] = (!to && !err && !w) ? st_hrdata[l] : 32'h0;
    cur = r + gap;
  endtask

  // single compare process against the schedule
  always @(negedge clk) begin
    if (run_en) begin
      chk($sformatf("cmd_ready@%0d", cyc_idx), {31'h0, cmd_ready}, {31'h0, ex_ready[cyc_idx]});
      chk($sformatf("htrans@%0d", cyc_idx), {30'h0, htrans}, {30'h0, ex_htrans[cyc_idx]});
      chk($sformatf("hwdata@%0d", cyc_idx), hwdata, ex_hwdata[cyc_idx]);
      chk($sformatf("rsp_valid@%0d", cyc_idx), {31'h0, rsp_valid}, {31'h0, ex_rv[cyc_idx]});
      chk($sformatf("hconst@%0d", cyc_idx), {24'h0, hburst, hmastlock, hprot}, 32'h3);
      if (ex_htrans[cyc_idx] == T_NONSEQ) begin
        chk($sformatf("haddr@%0d", cyc_idx), haddr, ex_haddr[cyc_idx]);
        chk($sformatf("hctl@%0d", cyc_idx), {28'h0, hwrite, hsize},
            {28'h0, ex_hwrite[cyc_idx], ex_hsize[cyc_idx]});
      end
      if (ex_rv[cyc_idx]) begin
        chk($sformatf("rsp_rdata@%0d", cyc_idx), rsp_rdata, ex_rdata[cyc_idx]);
        chk($sformatf("rsp_flags@%0d", cyc_idx), {30'h0, rsp_error, rsp_timeout},
            {30'h0, ex_rerr[cyc_idx], ex_rto[cyc_idx]});
        $display("txn cycle %0d: rsp_valid=%0b rdata=%h error=%0b timeout=%0b",
                 cyc_idx, rsp_valid, rsp_rdata, rsp_error, rsp_timeout);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ncyc, ast, dst, gap;
    logic rw, rerr;
    logic [31:0] ra, rwd;
    logic [2:0] rsz;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0; cmd_wdata = 32'h0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    for (int c = 0; c < MAXC; c++) begin
      st_valid[c] = 1'b0; st_write[c] = 1'b0; st_addr[c] = 32'h0; st_size[c] = 3'd0;
      st_wdata[c] = 32'h0; st_hready[c] = 1'($urandom_range(0, 1)); st_hresp[c] = 1'b0;
      st_hrdata[c] = $urandom;
      ex_ready[c] = 1'b1; ex_htrans[c] = T_IDLE; ex_haddr[c] = 32'h0; ex_hwrite[c] = 1'b0;
      ex_hsize[c] = 3'd0; ex_hwdata[c] = 32'h0; ex_rv[c] = 1'b0; ex_rdata[c] = 32'h0;
      ex_rerr[c] = 1'b0; ex_rto[c] = 1'b0;
    end
    cur = 2;

    // 1: zero-wait read
    st_hrdata[cur+2] = 32'h12345678;
    add_txn(1'b0, 32'hC0000010, 3'd2, 32'h0, 0, 0, 1'b0, 1, n);
    chk("pin1_nonseq", {30'h0, ex_htrans[n+1]}, {30'h0, T_NONSEQ});
    chk("pin1_data_idle", {30'h0, ex_htrans[n+2]}, {30'h0, T_IDLE});
    chk("pin1_rv", {31'h0, ex_rv[n+3]}, 32'h1);
    chk("pin1_rdata", ex_rdata[n+3], 32'h12345678);
    // 2: write with three data-phase wait states
    add_txn(1'b1, 32'hC0000018, 3'd2, 32'hDEADBEEF, 0, 3, 1'b0, 1, n);
    chk("pin2_hwdata_first", ex_hwdata[n+2], 32'hDEADBEEF);
    chk("pin2_hwdata_last", ex_hwdata[n+5], 32'hDEADBEEF);
    chk("pin2_rv_early", {31'h0, ex_rv[n+5]}, 32'h0);
    chk("pin2_rv", {31'h0, ex_rv[n+6]}, 32'h1);
    // 3: two-cycle ERROR
    add_txn(1'b0, 32'hC0000020, 3'd2, 32'h0, 0, 0, 1'b1, 1, n);
    chk("pin3_flags", {30'h0, ex_rerr[n+4], ex_rto[n+4]}, 32'h2);
    chk("pin3_rdata", ex_rdata[n+4], 32'h0);
    // 4: timeout after TO stalled cycles
    add_txn(1'b0, 32'hC0000024, 3'd2, 32'h0, 0, 10, 1'b0, 1, n);
    chk("pin4_flags", {30'h0, ex_rerr[n+6], ex_rto[n+6]}, 32'h1);
    chk("pin4_ready", {31'h0, ex_ready[n+6]}, 32'h1);
    // 5: misaligned word
    add_txn(1'b0, 32'hC0000012, 3'd2, 32'h0, 0, 0, 1'b0, 1, n);
    chk("pin5_no_nonseq", {30'h0, ex_htrans[n+1]}, {30'h0, T_IDLE});
    chk("pin5_err", {31'h0, ex_rerr[n+1]}, 32'h1);

    for (int t = 0; t < 160; t++) begin
      if (cur < MAXC - 80) begin
        rw   = 1'($urandom_range(0, 1));
        ra   = 32'hC0000000 | ($urandom & 32'h0000_00FF);
        rsz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        rwd  = $urandom;
        ast  = $urandom_range(0, 2);
        dst  = $urandom_range(0, 5);
        rerr = ($urandom_range(0, 4) == 0);
        gap  = $urandom_range(0, 2);
        add_txn(rw, ra, rsz, rwd, ast, dst, rerr, gap, n);
      end
    end
    ncyc = cur + 4;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_htrans", {30'h0, htrans}, 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_ctl", {24'h0, hwrite, hsize, hmastlock, hburst}, 32'h0);
    chk("rst_hprot", {28'h0, hprot}, 32'h3);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_rsp", {28'h0, rsp_valid, rsp_error, rsp_timeout, 1'b0}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    run_en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      cmd_valid = st_valid[c]; cmd_write = st_write[c]; cmd_addr = st_addr[c];
      cmd_size = st_size[c]; cmd_wdata = st_wdata[c];
      hready = st_hready[c]; hresp = st_hresp[c]; hrdata = st_hrdata[c];
      cyc_idx = c;
      @(posedge clk);
      #1;
    end
    run_en = 1'b0;

    // 6: asynchronous reset during the data phase of a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC0000030; cmd_size = 3'd2;
    cmd_wdata = 32'hA5A5A5A5; hready = 1'b1; hresp = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    hready = 1'b0;
    chk("r6_hwdata_before", hwdata, 32'hA5A5A5A5);
    #2;
    nreset = 1'b0;
    #1;
    chk("r6_htrans", {30'h0, htrans}, 32'h0);
    chk("r6_hwdata", hwdata, 32'h0);
    chk("r6_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    hready = 1'b1;
    @(posedge clk); #1;
    chk("r6_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("r6_htrans_after", {30'h0, htrans}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
